// File: rtl/prbs_check.sv
// prbs_check: self-synchronising PRBS checker for a Fibonacci LFSR sequence.
// The expected bit is predicted from the previously received bits. The checker
// acquires lock after a run of clean words, counts bit errors while locked, and
// drops lock after a run of errored words.
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   data_in     received word (REVERSE=0: MSB earliest in time, REVERSE=1: LSB earliest)
//   data_valid  data_in valid this cycle (no backpressure)
//   err_clear   clears err_count (pulse or level)
//   locked      checker locked
//   err_valid   one-cycle pulse when err_word/err_bits are updated
//   err_word    per-bit error mask of the last checked word (data_in bit order)
//   err_bits    popcount of err_word
//   err_count   saturating count of bit errors seen while locked
module prbs_check #(
  parameter int unsigned                  LFSR_WIDTH      = 31,
  parameter logic [LFSR_WIDTH-1:0]        LFSR_POLY       = 31'h10000001,
  parameter bit                           REVERSE         = 1'b0,
  parameter bit                           INVERT          = 1'b0,
  parameter int unsigned                  DATA_WIDTH      = 8,
  parameter int unsigned                  LOCK_COUNT      = 16,
  parameter int unsigned                  UNLOCK_COUNT    = 4,
  parameter int unsigned                  ERR_COUNT_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic                               data_valid,
  input  logic                               err_clear,
  output logic                               locked,
  output logic                               err_valid,
  output logic [DATA_WIDTH-1:0]              err_word,
  output logic [$clog2(DATA_WIDTH+1)-1:0]    err_bits,
  output logic [ERR_COUNT_WIDTH-1:0]         err_count
);

  localparam int unsigned EB_W       = $clog2(DATA_WIDTH + 1);
  localparam int unsigned FILL_WORDS = (LFSR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int unsigned FILL_W     = $clog2(FILL_WORDS + 1);
  localparam int unsigned GOOD_W     = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BAD_W      = $clog2(UNLOCK_COUNT + 1);
  localparam int unsigned SUM_W      = ((ERR_COUNT_WIDTH > EB_W) ? ERR_COUNT_WIDTH : EB_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({ERR_COUNT_WIDTH{1'b1}});

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [LFSR_WIDTH-1:0]      hist_q, hist_d;
  logic [FILL_W-1:0]          fill_cnt_q, fill_cnt_d;
  logic [GOOD_W-1:0]          good_cnt_q, good_cnt_d;
  logic [BAD_W-1:0]           bad_cnt_q, bad_cnt_d;
  logic                       locked_q, locked_d;
  logic                       err_valid_q, err_valid_d;
  logic [DATA_WIDTH-1:0]      err_word_q, err_word_d;
  logic [EB_W-1:0]            err_bits_q, err_bits_d;
  logic [ERR_COUNT_WIDTH-1:0] err_count_q, err_count_d;

  // Bit-serial prediction across the word; hist[j-1] holds r[n-j].
  logic [LFSR_WIDTH-1:0] hist_v;
  logic [DATA_WIDTH-1:0] raw_mask;
  logic [DATA_WIDTH-1:0] word_mask;
  logic [EB_W-1:0]       pop;
  logic                  hist_zero;
  logic                  rx_bit;
  logic                  exp_bit;
  int unsigned           idx;

  always_comb begin
    hist_v   = hist_q;
    raw_mask = '0;
    rx_bit   = 1'b0;
    exp_bit  = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
      idx     = REVERSE ? k : (DATA_WIDTH - 1 - k);
      rx_bit  = data_in[idx] ^ INVERT;
      exp_bit = hist_v[LFSR_WIDTH-1];
      for (int unsigned j = 1; j < LFSR_WIDTH; j++) begin
        if (LFSR_POLY[j]) exp_bit = exp_bit ^ hist_v[j-1];
      end
      raw_mask[idx] = rx_bit ^ exp_bit;
      hist_v        = {hist_v[LFSR_WIDTH-2:0], rx_bit};
    end
    hist_zero = (hist_v == '0);
    // An all-zero history is the LFSR lock-up state; while locked it counts as a dead link.
    word_mask = (state_q == ST_LOCKED && hist_zero) ? '1 : raw_mask;
    pop = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      pop = pop + EB_W'(word_mask[i]);
    end
  end

  // Saturating accumulation with err_clear taking priority.
  logic [SUM_W-1:0] sum_v;
  logic [SUM_W-1:0] clr_v;
  logic             counted;

  always_comb begin
    counted = data_valid && (state_q == ST_LOCKED);
    sum_v   = SUM_W'(err_count_q) + SUM_W'(pop);
    if (sum_v > CNT_MAX) sum_v = CNT_MAX;
    clr_v   = SUM_W'(pop);
    if (clr_v > CNT_MAX) clr_v = CNT_MAX;
    err_count_d = err_count_q;
    if (err_clear) begin
      err_count_d = counted ? ERR_COUNT_WIDTH'(clr_v) : '0;
    end else if (counted) begin
      err_count_d = ERR_COUNT_WIDTH'(sum_v);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_cnt_d  = fill_cnt_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    locked_d    = locked_q;
    err_valid_d = 1'b0;
    err_word_d  = err_word_q;
    err_bits_d  = err_bits_q;
    if (data_valid) begin
      hist_d = hist_v;
      case (state_q)
        ST_FILL: begin
          fill_cnt_d = fill_cnt_q + FILL_W'(1);
          if (fill_cnt_q == FILL_W'(FILL_WORDS - 1)) state_d = ST_SEARCH;
        end
        ST_SEARCH: begin
          err_valid_d = 1'b1;
          err_word_d  = word_mask;
          err_bits_d  = pop;
          if (pop == '0 && !hist_zero) begin
            good_cnt_d = good_cnt_q + GOOD_W'(1);
            if (good_cnt_q == GOOD_W'(LOCK_COUNT - 1)) begin
              state_d   = ST_LOCKED;
              locked_d  = 1'b1;
              bad_cnt_d = '0;
            end
          end else begin
            good_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          err_valid_d = 1'b1;
          err_word_d  = word_mask;
          err_bits_d  = pop;
          if (pop != '0) begin
            bad_cnt_d = bad_cnt_q + BAD_W'(1);
            if (bad_cnt_q == BAD_W'(UNLOCK_COUNT - 1)) begin
              state_d    = ST_SEARCH;
              locked_d   = 1'b0;
              good_cnt_d = '0;
            end
          end else begin
            bad_cnt_d = '0;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      hist_q      <= '0;
      fill_cnt_q  <= '0;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_valid_q <= 1'b0;
      err_word_q  <= '0;
      err_bits_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_cnt_q  <= fill_cnt_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      locked_q    <= locked_d;
      err_valid_q <= err_valid_d;
      err_word_q  <= err_word_d;
      err_bits_q  <= err_bits_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_valid = err_valid_q;
  assign err_word  = err_word_q;
  assign err_bits  = err_bits_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs_check.sv
// tb_prbs_check: directed test of prbs_check.
// u7  : PRBS7 (7'h41), 8-bit words, lock/unlock after 4 words, 32-bit counter.
// u7s : same checker with a 4-bit error counter for saturation and clear.
// u31 : inverted PRBS31, 32-bit LSB-first words.
module tb_prbs_check;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0]  d7,  ds;
  logic        v7,  vs,  c7,  cs;
  logic        l7,  ls,  ev7, evs;
  logic [7:0]  ew7, ews;
  logic [3:0]  eb7, ebs;
  logic [31:0] ec7;
  logic [3:0]  ecs;

  logic [31:0] d31, ew31, ec31;
  logic        v31, c31, l31, ev31;
  logic [5:0]  eb31;

  prbs_check #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .REVERSE(1'b0), .INVERT(1'b0),
               .DATA_WIDTH(8), .LOCK_COUNT(4), .UNLOCK_COUNT(4), .ERR_COUNT_WIDTH(32)) u7 (
    .clk(clk), .rst(rst), .data_in(d7), .data_valid(v7), .err_clear(c7),
    .locked(l7), .err_valid(ev7), .err_word(ew7), .err_bits(eb7), .err_count(ec7));

  prbs_check #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .REVERSE(1'b0), .INVERT(1'b0),
               .DATA_WIDTH(8), .LOCK_COUNT(4), .UNLOCK_COUNT(4), .ERR_COUNT_WIDTH(4)) u7s (
    .clk(clk), .rst(rst), .data_in(ds), .data_valid(vs), .err_clear(cs),
    .locked(ls), .err_valid(evs), .err_word(ews), .err_bits(ebs), .err_count(ecs));

  prbs_check #(.LFSR_WIDTH(31), .LFSR_POLY(31'h10000001), .REVERSE(1'b1), .INVERT(1'b1),
               .DATA_WIDTH(32), .LOCK_COUNT(4), .UNLOCK_COUNT(4), .ERR_COUNT_WIDTH(32)) u31 (
    .clk(clk), .rst(rst), .data_in(d31), .data_valid(v31), .err_clear(c31),
    .locked(l31), .err_valid(ev31), .err_word(ew31), .err_bits(eb31), .err_count(ec31));

  int vectors    = 0;
  int miscompares = 0;

  logic [6:0]  g7;
  logic [30:0] g31;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next 8 PRBS7 bits, earliest bit in the MSB.
  task automatic gen7(output logic [7:0] w);
    logic b;
    for (int k = 0; k < 8; k++) begin
      b = g7[5] ^ g7[6];
      w[7-k] = b;
      g7 = {g7[5:0], b};
    end
  endtask

  // Next 32 inverted PRBS31 bits, earliest bit in the LSB.
  task automatic gen31(output logic [31:0] w);
    logic b;
    for (int k = 0; k < 32; k++) begin
      b = g31[27] ^ g31[30];
      w[k] = ~b;
      g31 = {g31[29:0], b};
    end
  endtask

  task automatic send7(input logic [7:0] w, input logic clr);
    @(negedge clk); d7 = w; v7 = 1'b1; c7 = clr;
    @(posedge clk); #1; v7 = 1'b0; c7 = 1'b0;
  endtask

  task automatic sends(input logic [7:0] w, input logic clr);
    @(negedge clk); ds = w; vs = 1'b1; cs = clr;
    @(posedge clk); #1; vs = 1'b0; cs = 1'b0;
  endtask

  task automatic send31(input logic [31:0] w);
    @(negedge clk); d31 = w; v31 = 1'b1;
    @(posedge clk); #1; v31 = 1'b0;
  endtask

  logic [7:0]  w8;
  logic [31:0] w32;

  initial begin
    rst = 1'b1;
    d7 = '0; v7 = 1'b0; c7 = 1'b0;
    ds = '0; vs = 1'b0; cs = 1'b0;
    d31 = '0; v31 = 1'b0; c31 = 1'b0;
    g7  = 7'h7F;
    g31 = 31'h2A3B4C5D;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked",    64'(l7),   64'(0));
    chk("rst_err_valid", 64'(ev7),  64'(0));
    chk("rst_err_word",  64'(ew7),  64'(0));
    chk("rst_err_bits",  64'(eb7),  64'(0));
    chk("rst_err_count", 64'(ec7),  64'(0));
    chk("rst_locked31",  64'(l31),  64'(0));
    @(negedge clk); rst = 1'b0;

    // Clean PRBS7: one fill word, then four clean words to lock.
    gen7(w8); send7(w8, 1'b0);
    chk("fill_no_valid", 64'(ev7), 64'(0));
    gen7(w8); send7(w8, 1'b0);
    chk("w2_err_valid", 64'(ev7), 64'(1));
    chk("w2_err_bits",  64'(eb7), 64'(0));
    chk("w2_unlocked",  64'(l7),  64'(0));
    gen7(w8); send7(w8, 1'b0);
    gen7(w8); send7(w8, 1'b0);
    chk("w4_unlocked", 64'(l7), 64'(0));
    gen7(w8); send7(w8, 1'b0);
    chk("w5_locked",    64'(l7),  64'(1));
    chk("w5_err_count", 64'(ec7), 64'(0));
    @(posedge clk); #1;
    chk("idle_err_valid", 64'(ev7), 64'(0));
    gen7(w8); send7(w8, 1'b0);
    gen7(w8); send7(w8, 1'b0);
    chk("clean_err_count", 64'(ec7), 64'(0));

    // Single flipped bit at time slot 4: errors at slot 4, then slots 2 and 3 of the next word.
    gen7(w8); send7(w8 ^ 8'h08, 1'b0);
    chk("flip_err_word", 64'(ew7), 64'(8'h08));
    chk("flip_err_bits", 64'(eb7), 64'(1));
    gen7(w8); send7(w8, 1'b0);
    chk("flip_next_word",  64'(ew7), 64'(8'h30));
    chk("flip_next_bits",  64'(eb7), 64'(2));
    chk("flip_err_count",  64'(ec7), 64'(3));
    gen7(w8); send7(w8, 1'b0);
    chk("flip_still_lock", 64'(l7),  64'(1));
    chk("flip_clean_bits", 64'(eb7), 64'(0));

    // Inverted burst: 7 errors in the first word, 8 in each following word.
    gen7(w8); send7(~w8, 1'b0);
    chk("inv1_err_word", 64'(ew7), 64'(8'hFD));
    chk("inv1_err_bits", 64'(eb7), 64'(7));
    gen7(w8); send7(~w8, 1'b0);
    gen7(w8); send7(~w8, 1'b0);
    chk("inv3_err_bits", 64'(eb7), 64'(8));
    chk("inv3_locked",   64'(l7),  64'(1));
    gen7(w8); send7(~w8, 1'b0);
    chk("inv4_unlocked",  64'(l7),  64'(0));
    chk("inv4_err_count", 64'(ec7), 64'(34));

    // Return to clean data: one errored transition word, then four clean words re-lock.
    gen7(w8); send7(w8, 1'b0);
    chk("trans_err_word",  64'(ew7), 64'(8'h02));
    chk("trans_err_count", 64'(ec7), 64'(34));
    gen7(w8); send7(w8, 1'b0);
    gen7(w8); send7(w8, 1'b0);
    gen7(w8); send7(w8, 1'b0);
    chk("relock_pending", 64'(l7), 64'(0));
    gen7(w8); send7(w8, 1'b0);
    chk("relocked", 64'(l7), 64'(1));

    // All-zero input while locked: fully errored words, unlock after four.
    send7(8'h00, 1'b0);
    chk("zero1_err_bits", 64'(eb7), 64'(8));
    chk("zero1_err_word", 64'(ew7), 64'(8'hFF));
    send7(8'h00, 1'b0);
    send7(8'h00, 1'b0);
    chk("zero3_locked", 64'(l7), 64'(1));
    send7(8'h00, 1'b0);
    chk("zero4_unlocked",  64'(l7),  64'(0));
    chk("zero4_err_count", 64'(ec7), 64'(66));

    // err_clear without a counted word clears to zero.
    @(negedge clk); c7 = 1'b1;
    @(posedge clk); #1; c7 = 1'b0;
    chk("clear_idle", 64'(ec7), 64'(0));

    // All-zero words from reset never lock.
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      send7(8'h00, 1'b0);
      chk("zeros_never_lock", 64'(l7), 64'(0));
    end
    chk("zeros_err_count", 64'(ec7), 64'(0));

    // Saturation and err_clear on the 4-bit counter instance.
    g7 = 7'h7F;
    for (int i = 0; i < 5; i++) begin
      gen7(w8); sends(w8, 1'b0);
    end
    chk("sat_locked", 64'(ls), 64'(1));
    for (int i = 0; i < 4; i++) begin
      gen7(w8); sends(w8 ^ 8'h80, 1'b0);
      chk("sat_slot0_bits", 64'(ebs), 64'(3));
      gen7(w8); sends(w8, 1'b0);
    end
    chk("sat_count12", 64'(ecs), 64'(12));
    gen7(w8); sends(w8 ^ 8'h40, 1'b0);
    chk("sat_count14", 64'(ecs), 64'(14));
    gen7(w8); sends(w8 ^ 8'h40, 1'b0);
    chk("sat_add3_bits", 64'(ebs), 64'(3));
    chk("sat_count15",   64'(ecs), 64'(15));
    gen7(w8); sends(w8, 1'b0);
    chk("sat_no_wrap", 64'(ecs), 64'(15));
    chk("sat_locked2", 64'(ls),  64'(1));
    gen7(w8); sends(w8, 1'b0);
    gen7(w8); sends(w8 ^ 8'h40, 1'b1);
    chk("clear_bits",  64'(ebs), 64'(2));
    chk("clear_count", 64'(ecs), 64'(2));
    gen7(w8); sends(w8, 1'b0);
    chk("after_clear_count", 64'(ecs), 64'(3));

    // Inverted PRBS31, 32-bit LSB-first words.
    gen31(w32); send31(w32);
    chk("p31_fill", 64'(ev31), 64'(0));
    for (int i = 0; i < 3; i++) begin
      gen31(w32); send31(w32);
      chk("p31_clean_bits", 64'(eb31), 64'(0));
      chk("p31_unlocked",   64'(l31),  64'(0));
    end
    gen31(w32); send31(w32);
    chk("p31_locked",    64'(l31),  64'(1));
    chk("p31_err_count", 64'(ec31), 64'(0));
    // One flipped bit at slot 0: errors at slots 0, 28 and 31 of the same word.
    gen31(w32); send31(w32 ^ 32'h1);
    chk("p31_flip_word",  64'(ew31), 64'(32'h9000_0001));
    chk("p31_flip_count", 64'(ec31), 64'(3));

    // Reset while locked, with a valid word in the reset cycle.
    gen31(w32);
    @(negedge clk); rst = 1'b1; d31 = w32; v31 = 1'b1;
    @(posedge clk); #1; v31 = 1'b0;
    chk("p31_rst_locked",    64'(l31),  64'(0));
    chk("p31_rst_err_count", 64'(ec31), 64'(0));
    chk("p31_rst_err_valid", 64'(ev31), 64'(0));
    @(negedge clk); rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
